m72_color_mixer: RTL and testbench

// Downstream of the M72-B-D tile board. Takes per-pixel BIT/COL from tile layers A and B
// and the sprite (OBJ) stream, then resolves priority and looks up CPU-writable palette RAM.

---
 rtl/m72_color_mixer.sv | 154 +++++++++++++++
 tb/tb_m72_color_mixer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m72_color_mixer.sv
// Pixel mixer: resolves tile A/B/sprite priority, looks up a 3x512x5 CPU palette, drives 8-bit RGB.
// Latency 3 ce_pix; no backpressure, the pixel pipe stalls only while ce_pix is low; CPU port never stalls.
// Build option MIX_LAYER_MASK_EN adds layer_mask[2:0] ({obj,b,a}) to force sources transparent.
module m72_color_mixer #(
    parameter bit PIPE_BLANK = 1'b1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [3:0]  a_bit,
    input  logic [3:0]  a_col,
    input  logic        a_prio,
    input  logic [3:0]  b_bit,
    input  logic [3:0]  b_col,
    input  logic        b_prio,
    input  logic [3:0]  obj_bit,
    input  logic [3:0]  obj_col,
    input  logic        hblank,
    input  logic        vblank,
`ifdef MIX_LAYER_MASK_EN
    input  logic [2:0]  layer_mask,
`endif
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank_o,
    output logic        vblank_o
);

    logic [4:0]  pal_r [512];
    logic [4:0]  pal_g [512];
    logic [4:0]  pal_b [512];

    logic [3:0]  a_bit_q, a_col_q, b_bit_q, b_col_q, obj_bit_q, obj_col_q;
    logic        a_prio_q, b_prio_q, hb1_q, vb1_q;
    logic [2:0]  mask_s1;
    logic [8:0]  idx_d, idx_q;
    logic        hb2_q, vb2_q, hb3_q, vb3_q;
    logic [7:0]  red_q, green_q, blue_q;
    logic [15:0] cpu_dout_q;
    logic        a_vis, b_vis, o_vis;
    logic [10:0] unused_din;

    assign unused_din = cpu_din[15:5];

`ifdef MIX_LAYER_MASK_EN
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            mask_s1 <= 3'b000;
        end else if (ce_pix) begin
            mask_s1 <= layer_mask;
        end
    end
`else
    assign mask_s1 = 3'b000;
`endif

    // Masked sources are treated exactly like a zero pixel, so they also lose their prio override.
    always_comb begin
        a_vis = (a_bit_q != 4'd0) && !mask_s1[0];
        b_vis = (b_bit_q != 4'd0) && !mask_s1[1];
        o_vis = (obj_bit_q != 4'd0) && !mask_s1[2];
        idx_d = 9'h100;
        if (a_vis && a_prio_q)      idx_d = {1'b1, a_col_q, a_bit_q};
        else if (b_vis && b_prio_q) idx_d = {1'b1, b_col_q, b_bit_q};
        else if (o_vis)             idx_d = {1'b0, obj_col_q, obj_bit_q};
        else if (a_vis)             idx_d = {1'b1, a_col_q, a_bit_q};
        else if (b_vis)             idx_d = {1'b1, b_col_q, b_bit_q};
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            a_bit_q   <= '0;
            a_col_q   <= '0;
            a_prio_q  <= 1'b0;
            b_bit_q   <= '0;
            b_col_q   <= '0;
            b_prio_q  <= 1'b0;
            obj_bit_q <= '0;
            obj_col_q <= '0;
            hb1_q     <= 1'b0;
            vb1_q     <= 1'b0;
            idx_q     <= '0;
            hb2_q     <= 1'b0;
            vb2_q     <= 1'b0;
            hb3_q     <= 1'b0;
            vb3_q     <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else if (ce_pix) begin
            a_bit_q   <= a_bit;
            a_col_q   <= a_col;
            a_prio_q  <= a_prio;
            b_bit_q   <= b_bit;
            b_col_q   <= b_col;
            b_prio_q  <= b_prio;
            obj_bit_q <= obj_bit;
            obj_col_q <= obj_col;
            hb1_q     <= hblank;
            vb1_q     <= vblank;
            idx_q     <= idx_d;
            hb2_q     <= hb1_q;
            vb2_q     <= vb1_q;
            hb3_q     <= hb2_q;
            vb3_q     <= vb2_q;
            // Palette read sees pre-write contents when the CPU writes the same entry this edge.
            if (PIPE_BLANK && (hb2_q || vb2_q)) begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end else begin
                red_q   <= {pal_r[idx_q], pal_r[idx_q][4:2]};
                green_q <= {pal_g[idx_q], pal_g[idx_q][4:2]};
                blue_q  <= {pal_b[idx_q], pal_b[idx_q][4:2]};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (cpu_cs && cpu_we) begin
            case (cpu_addr[10:9])
                2'b00:   pal_r[cpu_addr[8:0]] <= cpu_din[4:0];
                2'b01:   pal_g[cpu_addr[8:0]] <= cpu_din[4:0];
                default: pal_b[cpu_addr[8:0]] <= cpu_din[4:0];
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cpu_dout_q <= '0;
        end else if (cpu_cs && !cpu_we) begin
            case (cpu_addr[10:9])
                2'b00:   cpu_dout_q <= {11'd0, pal_r[cpu_addr[8:0]]};
                2'b01:   cpu_dout_q <= {11'd0, pal_g[cpu_addr[8:0]]};
                default: cpu_dout_q <= {11'd0, pal_b[cpu_addr[8:0]]};
            endcase
        end
    end

    assign cpu_dout = cpu_dout_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign hblank_o = hb3_q;
    assign vblank_o = vb3_q;

endmodule

// File: tb/tb_m72_color_mixer.sv
// Bench for m72_color_mixer: random pixel/CPU traffic against a palette/priority model with a scoreboard.
module tb_m72_color_mixer;

    localparam bit PIPE_BLANK = 1'b1;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [3:0]  a_bit = '0, a_col = '0, b_bit = '0, b_col = '0, obj_bit = '0, obj_col = '0;
    logic        a_prio = 1'b0, b_prio = 1'b0, hblank = 1'b0, vblank = 1'b0;
    logic [2:0]  layer_mask = '0;
    logic        cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic [7:0]  red, green, blue;
    logic        hblank_o, vblank_o;

    always #5 sys_clk = ~sys_clk;

    m72_color_mixer #(.PIPE_BLANK(PIPE_BLANK)) dut (
        .sys_clk(sys_clk), .reset(reset), .ce_pix(ce_pix),
        .a_bit(a_bit), .a_col(a_col), .a_prio(a_prio),
        .b_bit(b_bit), .b_col(b_col), .b_prio(b_prio),
        .obj_bit(obj_bit), .obj_col(obj_col),
        .hblank(hblank), .vblank(vblank),
`ifdef MIX_LAYER_MASK_EN
        .layer_mask(layer_mask),
`endif
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .red(red), .green(green), .blue(blue),
        .hblank_o(hblank_o), .vblank_o(vblank_o)
    );

    typedef struct packed {
        logic [3:0] a_bit, a_col;
        logic       a_prio;
        logic [3:0] b_bit, b_col;
        logic       b_prio;
        logic [3:0] obj_bit, obj_col;
        logic       hb, vb;
        logic [2:0] mask;
    } px_t;

    typedef struct packed {
        logic [8:0] idx;
        logic       hb, vb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          pal[3][512];
    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_rgb = '0;
    logic        exp_hb = 1'b0, exp_vb = 1'b0;
    logic        rgb_known = 1'b0, dout_known = 1'b0;
    logic [15:0] exp_dout = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] expand(input int v);
        return 8'((v << 3) | (v >> 2));
    endfunction

    function automatic int plane(input logic [10:0] a);
        return (a[10:9] == 2'b11) ? 2 : int'(a[10:9]);
    endfunction

    // Which palette entry a pixel shows: prio tiles, then sprite, then plain tiles, else backdrop.
    function automatic logic [8:0] resolve(input px_t p);
        bit av, bv, ov;
        av = (p.a_bit != 0) && !p.mask[0];
        bv = (p.b_bit != 0) && !p.mask[1];
        ov = (p.obj_bit != 0) && !p.mask[2];
        if (av && p.a_prio) return {1'b1, p.a_col, p.a_bit};
        if (bv && p.b_prio) return {1'b1, p.b_col, p.b_bit};
        if (ov)             return {1'b0, p.obj_col, p.obj_bit};
        if (av)             return {1'b1, p.a_col, p.a_bit};
        if (bv)             return {1'b1, p.b_col, p.b_bit};
        return 9'h100;
    endfunction

    // Model side: each ce_pix edge shows the pixel issued two ce_pix edges earlier.
    always @(posedge sys_clk) begin
        if (reset) begin
            exp_q.delete();
            exp_rgb = '0; exp_hb = 1'b0; exp_vb = 1'b0;
            rgb_known = 1'b1; exp_dout = '0; dout_known = 1'b1;
        end else begin
            if (ce_pix) begin
                if (exp_q.size() >= 3) begin
                    cur = exp_q.pop_front();
                    exp_hb = cur.hb;
                    exp_vb = cur.vb;
                    if (PIPE_BLANK && (cur.hb || cur.vb))
                        exp_rgb = '0;
                    else
                        exp_rgb = {expand(pal[0][cur.idx]), expand(pal[1][cur.idx]), expand(pal[2][cur.idx])};
                    rgb_known = 1'b1;
                end else begin
                    rgb_known = 1'b0;
                end
            end
            if (cpu_cs && !cpu_we) exp_dout = 16'(pal[plane(cpu_addr)][cpu_addr[8:0]]);
            if (cpu_cs && cpu_we) pal[plane(cpu_addr)][cpu_addr[8:0]] = int'(cpu_din[4:0]);
        end
    end

    always @(negedge sys_clk) begin
        if (rgb_known) begin
            chk("rgb", {8'd0, red, green, blue}, {8'd0, exp_rgb});
            chk("hblank_o", {31'd0, hblank_o}, {31'd0, exp_hb});
            chk("vblank_o", {31'd0, vblank_o}, {31'd0, exp_vb});
        end
        if (dout_known) chk("cpu_dout", {16'd0, cpu_dout}, {16'd0, exp_dout});
    end

    task automatic step(input px_t p, input logic ce, input logic cs, input logic we,
                        input logic [10:0] addr, input logic [15:0] din);
        exp_t e;
        @(negedge sys_clk);
        #1;
`ifndef MIX_LAYER_MASK_EN
        p.mask = 3'b000;
`endif
        a_bit = p.a_bit; a_col = p.a_col; a_prio = p.a_prio;
        b_bit = p.b_bit; b_col = p.b_col; b_prio = p.b_prio;
        obj_bit = p.obj_bit; obj_col = p.obj_col;
        hblank = p.hb; vblank = p.vb; layer_mask = p.mask;
        ce_pix = ce; cpu_cs = cs; cpu_we = we; cpu_addr = addr; cpu_din = din;
        if (ce && !reset) begin
            e.idx = resolve(p);
            e.hb = p.hb;
            e.vb = p.vb;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [3:0] rnd_bit();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endfunction

    function automatic px_t rand_px();
        px_t p;
        p.a_bit = rnd_bit(); p.a_col = 4'($urandom); p.a_prio = 1'($urandom);
        p.b_bit = rnd_bit(); p.b_col = 4'($urandom); p.b_prio = 1'($urandom);
        p.obj_bit = rnd_bit(); p.obj_col = 4'($urandom);
        p.hb = ($urandom_range(0, 9) == 0);
        p.vb = ($urandom_range(0, 19) == 0);
        p.mask = 3'($urandom);
        return p;
    endfunction

    initial begin
        px_t z, p, pb, rp;
        logic ce, cs;
        z = '0;

        repeat (3) step(z, 0, 0, 0, '0, '0);
        chk("reset_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("reset_blank_o", {30'd0, hblank_o, vblank_o}, 32'd0);
        chk("reset_dout", {16'd0, cpu_dout}, 32'd0);
        reset = 1'b0;

        for (int pl = 0; pl < 3; pl++)
            for (int i = 0; i < 512; i++)
                step(z, 0, 1, 1, {2'(pl), 9'(i)}, 16'($urandom));
        step(z, 0, 1, 1, 11'h100, 16'd31);
        step(z, 0, 1, 1, 11'h300, 16'd0);
        step(z, 0, 1, 1, 11'h500, 16'd16);

        step(z, 0, 1, 1, 11'h405, 16'h0017);
        step(z, 0, 1, 0, 11'h405, 16'h0000);
        step(z, 0, 0, 0, '0, '0);
        chk("cpu_read_405", {16'd0, cpu_dout}, 32'h0017);
        step(z, 0, 1, 1, 11'h605, 16'hFFE9);
        step(z, 0, 1, 0, 11'h405, 16'h0000);
        step(z, 0, 0, 0, '0, '0);
        chk("cpu_alias_605", {16'd0, cpu_dout}, 32'h0009);

        repeat (4) step(z, 1, 0, 0, '0, '0);
        step(z, 0, 0, 0, '0, '0);
        chk("backdrop_rgb", {8'd0, red, green, blue}, 32'h00FF0084);
        step(z, 0, 0, 0, '0, '0);
        chk("backdrop_hold", {8'd0, red, green, blue}, 32'h00FF0084);

        p = z; p.a_bit = 4'd5; p.a_col = 4'd2; p.obj_bit = 4'd3; p.obj_col = 4'd1;
        step(z, 0, 1, 1, 11'h013, 16'd7);
        step(z, 0, 1, 1, 11'h125, 16'd10);
        repeat (3) step(p, 1, 0, 0, '0, '0);
        step(z, 0, 0, 0, '0, '0);
        chk("prio_obj_over_a", {24'd0, red}, 32'h39);

`ifdef MIX_LAYER_MASK_EN
        p.a_prio = 1'b1; p.mask = 3'b001;
        repeat (3) step(p, 1, 0, 0, '0, '0);
        step(z, 0, 0, 0, '0, '0);
        chk("mask_a_prio", {24'd0, red}, 32'h39);
        p.mask = 3'b000;
`endif

        p.a_prio = 1'b1;
        repeat (4) step(p, 1, 0, 0, '0, '0);
        chk("prio_a_over_obj", {24'd0, red}, 32'h52);
        step(p, 1, 1, 1, 11'h125, 16'h0015);
        step(p, 0, 0, 0, '0, '0);
        chk("collide_old", {24'd0, red}, 32'h52);
        step(p, 1, 0, 0, '0, '0);
        step(p, 0, 0, 0, '0, '0);
        chk("collide_new", {24'd0, red}, 32'hAD);

        pb = p; pb.hb = 1'b1;
        step(pb, 1, 0, 0, '0, '0);
        step(p, 1, 0, 0, '0, '0);
        step(p, 1, 0, 0, '0, '0);
        step(p, 0, 0, 0, '0, '0);
        chk("hblank_rgb0", {8'd0, red, green, blue}, 32'd0);
        chk("hblank_o_dly", {31'd0, hblank_o}, 32'd1);

        for (int i = 0; i < 4000; i++) begin
            ce = (i % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            cs = ($urandom_range(0, 7) == 0);
            if (i >= 2000 && i <= 2003) begin
                ce = 1'b0;
                cs = 1'b0;
            end
            rp = rand_px();
            step(rp, ce, cs, 1'($urandom), 11'($urandom), 16'($urandom));
            if (i == 2000) begin
                reset = 1'b1;
                #1;
                chk("rst_async_rgb", {8'd0, red, green, blue}, 32'd0);
                chk("rst_async_blank_o", {30'd0, hblank_o, vblank_o}, 32'd0);
            end
            if (i == 2003) reset = 1'b0;
        end

        repeat (4) step(z, 0, 0, 0, '0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
